// File: rtl/colorspace_matrix.sv
// -----------------------------------------------------------------------------
// colorspace_matrix
// 3x3 colour-space converter with per-row offsets for the CSC stage.
//   dout[i] = clamp(round(sum_j C[i][j] * din[j]) + OFS[i]) into [0, 2^DATA_W-1]
// Coefficients are written into a shadow set and copied to the active set
// only on the first valid pixel of a frame after a commit request. This keeps
// a single frame from being converted with two different matrices.
//
// Pipeline (fixed latency 4, din at edge N -> dout at edge N+4):
//   S1 input + coefficient snapshot, S2 nine products, S3 row sums with
//   offset and rounding constant, S4 shift down and clamp.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   din_valid/din_sof   input qualifier / first pixel of frame
//   din0..din2          input components (unsigned DATA_W)
//   dout_valid/dout_sof output qualifier / delayed sof
//   dout0..dout2        output components, held while dout_valid = 0
//   coef_we/addr/wdata  shadow write port (0..8 matrix, 9..11 offsets)
//   coef_commit         request shadow->active copy at next accepted SOF
//   commit_pend         commit requested but not yet applied
//   bypass              only with CSC_BYPASS_EN defined: pass pixel through
//
// Optional feature macro: CSC_BYPASS_EN
// -----------------------------------------------------------------------------
module colorspace_matrix #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 18,
    parameter int FRAC_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic              din_sof,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    output logic              dout_valid,
    output logic              dout_sof,
    output logic [DATA_W-1:0] dout0,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              coef_commit,
    output logic              commit_pend
`ifdef CSC_BYPASS_EN
    ,
    input  logic              bypass
`endif
);

    // Internal width: product (DATA_W+1 x COEF_W) plus headroom for three
    // terms, offset and rounding constant.
    localparam int IW = DATA_W + COEF_W + 3;
    localparam int OW = DATA_W + 1;

    localparam logic signed [IW-1:0] L_RND = $signed(IW'(1'b1) << (FRAC_W - 1));
    localparam logic signed [IW-1:0] L_MAX = $signed(IW'({DATA_W{1'b1}}));

    // Identity matrix entry: diagonal positions are 0, 4 and 8.
    function automatic logic signed [COEF_W-1:0] ident_coef(input int idx);
        if ((idx % 4) == 0) begin
            return $signed(COEF_W'(1'b1) << FRAC_W);
        end else begin
            return '0;
        end
    endfunction

    // Arithmetic shift down to integer and saturate to the output range.
    function automatic logic [DATA_W-1:0] clamp_pix(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] s;
        s = v >>> FRAC_W;
        if (s[IW-1]) begin
            return '0;
        end else if (s > L_MAX) begin
            return {DATA_W{1'b1}};
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

    // Coefficient storage and commit state
    logic signed [COEF_W-1:0] r_sh_c [9];
    logic signed [OW-1:0]     r_sh_o [3];
    logic signed [COEF_W-1:0] r_ac_c [9];
    logic signed [OW-1:0]     r_ac_o [3];
    logic                     r_commit_pend;

    logic signed [COEF_W-1:0] w_sh_c_nx [9];
    logic signed [OW-1:0]     w_sh_o_nx [3];
    logic signed [COEF_W-1:0] w_use_c   [9];
    logic signed [OW-1:0]     w_use_o   [3];
    logic                     w_apply;
    logic                     w_byp_in;

    // Pipeline registers
    logic                     r_s1_valid, r_s1_sof, r_s1_byp;
    logic [DATA_W-1:0]        r_s1_d [3];
    logic signed [COEF_W-1:0] r_s1_c [9];
    logic signed [OW-1:0]     r_s1_o [3];

    logic                     r_s2_valid, r_s2_sof, r_s2_byp;
    logic [DATA_W-1:0]        r_s2_d [3];
    logic signed [IW-1:0]     r_s2_p [9];
    logic signed [OW-1:0]     r_s2_o [3];

    logic                     r_s3_valid, r_s3_sof, r_s3_byp;
    logic [DATA_W-1:0]        r_s3_d [3];
    logic signed [IW-1:0]     r_s3_sum [3];

    logic signed [IW-1:0]     w_p   [9];
    logic signed [IW-1:0]     w_sum [3];

    logic                     r_dout_valid, r_dout_sof;
    logic [DATA_W-1:0]        r_dout [3];

`ifdef CSC_BYPASS_EN
    assign w_byp_in = bypass;
`else
    assign w_byp_in = 1'b0;
`endif

    // A commit lands on the first valid SOF pixel, whether requested earlier
    // or in the same cycle.
    assign w_apply = (r_commit_pend | coef_commit) & din_valid & din_sof;

    // Shadow set as it will be after this cycle's write, and the set the
    // current pixel must use (the new one when a commit lands on it).
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            if (coef_we && (coef_addr == 4'(i))) begin
                w_sh_c_nx[i] = $signed(coef_wdata);
            end else begin
                w_sh_c_nx[i] = r_sh_c[i];
            end
            if (w_apply) begin
                w_use_c[i] = w_sh_c_nx[i];
            end else begin
                w_use_c[i] = r_ac_c[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (coef_we && (coef_addr == 4'(9 + i))) begin
                w_sh_o_nx[i] = $signed(coef_wdata[OW-1:0]);
            end else begin
                w_sh_o_nx[i] = r_sh_o[i];
            end
            if (w_apply) begin
                w_use_o[i] = w_sh_o_nx[i];
            end else begin
                w_use_o[i] = r_ac_o[i];
            end
        end
    end

    // Shadow/active coefficient sets and the pending-commit flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                r_sh_c[i] <= ident_coef(i);
                r_ac_c[i] <= ident_coef(i);
            end
            for (int i = 0; i < 3; i++) begin
                r_sh_o[i] <= '0;
                r_ac_o[i] <= '0;
            end
            r_commit_pend <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                r_sh_c[i] <= w_sh_c_nx[i];
                r_ac_c[i] <= w_use_c[i];
            end
            for (int i = 0; i < 3; i++) begin
                r_sh_o[i] <= w_sh_o_nx[i];
                r_ac_o[i] <= w_use_o[i];
            end
            if (w_apply) begin
                r_commit_pend <= 1'b0;
            end else if (coef_commit) begin
                r_commit_pend <= 1'b1;
            end else begin
                r_commit_pend <= r_commit_pend;
            end
        end
    end

    // Products for S2 and row sums for S3; din is zero-extended so it is
    // treated as a non-negative signed value.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_p[i] = IW'($signed({1'b0, r_s1_d[i % 3]})) * IW'(r_s1_c[i]);
        end
        for (int r = 0; r < 3; r++) begin
            w_sum[r] = r_s2_p[r*3] + r_s2_p[r*3+1] + r_s2_p[r*3+2]
                     + (IW'(r_s2_o[r]) <<< FRAC_W) + L_RND;
        end
    end

    // Stage 1: capture pixel, qualifiers and the coefficient snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_byp   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_s1_d[i] <= '0;
                r_s1_o[i] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                r_s1_c[i] <= '0;
            end
        end else begin
            r_s1_valid <= din_valid;
            r_s1_sof   <= din_valid & din_sof;
            r_s1_byp   <= w_byp_in;
            r_s1_d[0]  <= din0;
            r_s1_d[1]  <= din1;
            r_s1_d[2]  <= din2;
            for (int i = 0; i < 3; i++) begin
                r_s1_o[i] <= w_use_o[i];
            end
            for (int i = 0; i < 9; i++) begin
                r_s1_c[i] <= w_use_c[i];
            end
        end
    end

    // Stages 2 and 3: products, then row sums; raw pixel travels alongside
    // for bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_byp   <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_sof   <= 1'b0;
            r_s3_byp   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_s2_p[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                r_s2_d[i]   <= '0;
                r_s2_o[i]   <= '0;
                r_s3_d[i]   <= '0;
                r_s3_sum[i] <= '0;
            end
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_sof   <= r_s1_sof;
            r_s2_byp   <= r_s1_byp;
            r_s3_valid <= r_s2_valid;
            r_s3_sof   <= r_s2_sof;
            r_s3_byp   <= r_s2_byp;
            for (int i = 0; i < 9; i++) begin
                r_s2_p[i] <= w_p[i];
            end
            for (int i = 0; i < 3; i++) begin
                r_s2_d[i]   <= r_s1_d[i];
                r_s2_o[i]   <= r_s1_o[i];
                r_s3_d[i]   <= r_s2_d[i];
                r_s3_sum[i] <= w_sum[i];
            end
        end
    end

    // Stage 4: shift/clamp into output registers; data holds between pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
            r_dout_sof   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_dout[i] <= '0;
            end
        end else begin
            r_dout_valid <= r_s3_valid;
            r_dout_sof   <= r_s3_sof;
            for (int i = 0; i < 3; i++) begin
                if (r_s3_valid && r_s3_byp) begin
                    r_dout[i] <= r_s3_d[i];
                end else if (r_s3_valid) begin
                    r_dout[i] <= clamp_pix(r_s3_sum[i]);
                end else begin
                    r_dout[i] <= r_dout[i];
                end
            end
        end
    end

    assign dout_valid  = r_dout_valid;
    assign dout_sof    = r_dout_sof;
    assign dout0       = r_dout[0];
    assign dout1       = r_dout[1];
    assign dout2       = r_dout[2];
    assign commit_pend = r_commit_pend;

endmodule

// File: tb/tb_colorspace_matrix.sv
// Directed bench for colorspace_matrix. The driver pushes the hand-computed
// expected pixel and its due cycle into a queue; an independent monitor pops
// and compares whenever dout_valid is seen.
module tb_colorspace_matrix;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid, din_sof;
    logic [11:0] din0, din1, din2;
    logic        dout_valid, dout_sof;
    logic [11:0] dout0, dout1, dout2;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [17:0] coef_wdata;
    logic        coef_commit;
    logic        commit_pend;
`ifdef CSC_BYPASS_EN
    logic        bypass;
`endif

    colorspace_matrix dut (
        .clk(clk), .rst(rst),
        .din_valid(din_valid), .din_sof(din_sof),
        .din0(din0), .din1(din1), .din2(din2),
        .dout_valid(dout_valid), .dout_sof(dout_sof),
        .dout0(dout0), .dout1(dout1), .dout2(dout2),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_commit(coef_commit), .commit_pend(commit_pend)
`ifdef CSC_BYPASS_EN
        , .bypass(bypass)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [11:0] d0, d1, d2;
        logic        sof;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_bad = 0;

    // Monitor: compare every presented output against the queue head.
    always @(negedge clk) begin
        if (dout_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got dout_valid=1 at cycle %0d, required no output", cyc);
            end else begin
                m_e = sb.pop_front();
                if (dout0 !== m_e.d0 || dout1 !== m_e.d1 || dout2 !== m_e.d2 ||
                    dout_sof !== m_e.sof || cyc != m_e.due) begin
                    n_bad++;
                    $display("FAIL pixel: got (%0d,%0d,%0d) sof=%0d cycle=%0d, required (%0d,%0d,%0d) sof=%0d cycle=%0d",
                             dout0, dout1, dout2, dout_sof, cyc,
                             m_e.d0, m_e.d1, m_e.d2, m_e.sof, m_e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [17:0] v);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = v;
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    // One pixel; the output is due four edges after the edge it was driven at.
    task automatic px(input logic sof, input logic cm,
                      input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2,
                      input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2);
        exp_t e;
        din_valid   = 1'b1;
        din_sof     = sof;
        coef_commit = cm;
        din0 = d0; din1 = d1; din2 = d2;
        e.d0 = e0; e.d1 = e1; e.d2 = e2; e.sof = sof; e.due = cyc + 4;
        sb.push_back(e);
        tick();
        din_valid   = 1'b0;
        din_sof     = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_dout0"}, int'(dout0), 0);
        chk({nm, "_dout1"}, int'(dout1), 0);
        chk({nm, "_dout2"}, int'(dout2), 0);
        chk({nm, "_valid"}, int'(dout_valid), 0);
        chk({nm, "_sof"}, int'(dout_sof), 0);
        chk({nm, "_pend"}, int'(commit_pend), 0);
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0;
        din0 = 12'd0; din1 = 12'd0; din2 = 12'd0;
        coef_we = 1'b0; coef_addr = 4'd0; coef_wdata = 18'd0; coef_commit = 1'b0;
`ifdef CSC_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // Identity after reset
        px(1'b0, 1'b0, 12'd100, 12'd200, 12'd300, 12'd100, 12'd200, 12'd300);
        repeat (6) tick();

        // Clamp high and low: C00 = 2.0, OFS1 = -50
        wr(4'd0, 18'd32768);
        wr(4'd10, -18'sd50);
        commit();
        chk("clamp_pend_set", int'(commit_pend), 1);
        px(1'b1, 1'b0, 12'd3000, 12'd20, 12'd5, 12'd4095, 12'd0, 12'd5);
        chk("clamp_pend_clr", int'(commit_pend), 0);
        px(1'b0, 1'b0, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4045, 12'd4095);

        // Rounding with C00 = 0.5; commit lands in the same cycle as SOF
        wr(4'd0, 18'd8192);
        px(1'b1, 1'b1, 12'd3, 12'd100, 12'd7, 12'd2, 12'd50, 12'd7);
        chk("same_cycle_commit_pend", int'(commit_pend), 0);
        px(1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
        px(1'b0, 1'b0, 12'd1, 12'd100, 12'd7, 12'd1, 12'd50, 12'd7);
        repeat (6) tick();

        // Clean reset restores identity and clears outputs
        rst = 1'b1;
        repeat (2) tick();
        chk_reset("reset2");
        rst = 1'b0;

        // Commit waits for SOF; sof without valid is ignored
        wr(4'd0, 18'd0);
        commit();
        chk("commit_pend_set", int'(commit_pend), 1);
        px(1'b0, 1'b0, 12'd10, 12'd20, 12'd30, 12'd10, 12'd20, 12'd30);
        din_sof = 1'b1;
        tick();
        din_sof = 1'b0;
        chk("sof_no_valid_pend", int'(commit_pend), 1);
        px(1'b0, 1'b0, 12'd11, 12'd21, 12'd31, 12'd11, 12'd21, 12'd31);
        chk("pend_before_sof", int'(commit_pend), 1);
        px(1'b1, 1'b0, 12'd40, 12'd50, 12'd60, 12'd0, 12'd50, 12'd60);
        chk("pend_after_sof", int'(commit_pend), 0);
        px(1'b0, 1'b0, 12'd70, 12'd80, 12'd90, 12'd0, 12'd80, 12'd90);
        repeat (6) tick();

        // Reset with two pixels in flight and a commit pending
        wr(4'd0, 18'd16384);
        commit();
        chk("midreset_pend_set", int'(commit_pend), 1);
        px(1'b0, 1'b0, 12'd1, 12'd2, 12'd3, 12'd0, 12'd2, 12'd3);
        px(1'b0, 1'b0, 12'd4, 12'd5, 12'd6, 12'd0, 12'd5, 12'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("midreset_pend", int'(commit_pend), 0);
        chk("midreset_valid", int'(dout_valid), 0);
        repeat (6) tick();
        px(1'b0, 1'b0, 12'd123, 12'd456, 12'd789, 12'd123, 12'd456, 12'd789);
        px(1'b1, 1'b0, 12'd5, 12'd6, 12'd7, 12'd5, 12'd6, 12'd7);
        repeat (6) tick();

`ifdef CSC_BYPASS_EN
        // Bypass with a non-identity active set
        wr(4'd0, 18'd8192);
        commit();
        px(1'b1, 1'b0, 12'd100, 12'd10, 12'd10, 12'd50, 12'd10, 12'd10);
        bypass = 1'b1;
        px(1'b0, 1'b0, 12'd7, 12'd8, 12'd9, 12'd7, 12'd8, 12'd9);
        bypass = 1'b0;
        px(1'b0, 1'b0, 12'd100, 12'd8, 12'd9, 12'd50, 12'd8, 12'd9);
        repeat (6) tick();
`endif

        // Bounded drain: every queued pixel must have appeared
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("drain_outstanding", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
